fifo_rr_sched: RTL and testbench

Round-robin pop scheduler. It drains N_SRC independent fifo instances into one downstream consumer over a valid/ready interface, and tags each word with its source index. It sits between the per-source feature/result queues and the shared tree-evaluation engine. It issues one-cycle pop pulses, accounts for the fifo's 1-cycle registered read latency, and holds the word until the consumer accepts it.

---
 rtl/fifo_rr_sched.sv | 140 ++++++++++++++
 tb/tb_fifo_rr_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_sched.sv
// Round-robin pop scheduler: drains N_SRC registered-read fifos into one
// valid/ready consumer and tags each forwarded word with its source index.
module fifo_rr_sched #(
  parameter int N_SRC = 4,
  parameter int WIDTH = 16,
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic [N_SRC-1:0]       i_empty,
  output logic [N_SRC-1:0]       o_pop,
  input  logic [N_SRC*WIDTH-1:0] i_front,
  input  logic [N_SRC-1:0]       i_front_vld,
  output logic [WIDTH-1:0]       o_data,
  output logic [SW-1:0]          o_src_id,
  output logic                   o_vld,
  input  logic                   i_rdy,
  output logic                   o_busy,
  output logic                   o_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_r;
  logic [SW-1:0]    rr_ptr_r;
  logic [SW-1:0]    gsel_r;
  logic [SW-1:0]    grant_s;
  logic [SW-1:0]    rr_next_s;
  logic [SW-1:0]    scan_idx_s;
  logic             grant_vld_s;
  logic             pop_en_s;
  logic [WIDTH-1:0] front_s [N_SRC];

  // Unpack the flat front-data bus into one word per source.
  always_comb begin
    for (int k = 0; k < N_SRC; k++) begin
      front_s[k] = i_front[k*WIDTH +: WIDTH];
    end
  end

  // Rotating-priority arbiter; scanning from the far end lets the closest
  // non-empty source to rr_ptr win the last assignment.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = '0;
    scan_idx_s  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      scan_idx_s = SW'((int'(rr_ptr_r) + i) % N_SRC);
      if (!i_empty[scan_idx_s]) begin
        grant_vld_s = 1'b1;
        grant_s     = scan_idx_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    if (grant_s == SW'(N_SRC - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_s + SW'(1);
    end
  end

  // Pop issue: only from IDLE, or from HOLD on the accepting handshake.
  always_comb begin
    pop_en_s = 1'b0;
    if (i_flush) begin
      pop_en_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: pop_en_s = grant_vld_s;
        ST_HOLD: pop_en_s = grant_vld_s & i_rdy;
        default: pop_en_s = 1'b0;
      endcase
    end
    o_pop = '0;
    for (int k = 0; k < N_SRC; k++) begin
      o_pop[k] = pop_en_s && (grant_s == SW'(k));
    end
  end

  assign o_busy = (state_r != ST_IDLE);

  // Scheduler FSM with registered word, tag, valid and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= '0;
      gsel_r   <= '0;
      o_data   <= '0;
      o_src_id <= '0;
      o_vld    <= 1'b0;
      o_err    <= 1'b0;
    end else if (i_flush) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= '0;
      o_vld    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_vld_s) begin
            gsel_r   <= grant_s;
            rr_ptr_r <= rr_next_s;
            state_r  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          o_data   <= front_s[gsel_r];
          o_src_id <= gsel_r;
          o_vld    <= 1'b1;
          state_r  <= ST_HOLD;
          if (!i_front_vld[gsel_r]) begin
            o_err <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (i_rdy) begin
            o_vld <= 1'b0;
            if (grant_vld_s) begin
              gsel_r   <= grant_s;
              rr_ptr_r <= rr_next_s;
              state_r  <= ST_WAIT;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          o_vld   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Scoreboard bench for fifo_rr_sched: a behavioural fifo model feeds the DUT,
// directed scenarios push hand-computed {data, src} words, a monitor checks them.
module tb_fifo_rr_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           i_flush;
  logic [N-1:0]   i_empty;
  logic [N-1:0]   o_pop;
  logic [N*W-1:0] i_front;
  logic [N-1:0]   i_front_vld;
  logic [W-1:0]   o_data;
  logic [1:0]     o_src_id;
  logic           o_vld;
  logic           i_rdy;
  logic           o_busy;
  logic           o_err;

  fifo_rr_sched #(.N_SRC(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_empty(i_empty),
    .o_pop(o_pop), .i_front(i_front), .i_front_vld(i_front_vld),
    .o_data(o_data), .o_src_id(o_src_id), .o_vld(o_vld), .i_rdy(i_rdy),
    .o_busy(o_busy), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]  fq [N][$];
  logic [W-1:0]  front_r [N];
  logic [N-1:0]  fv;
  logic          kill_vld;
  logic [N-1:0]  last_pop;
  logic [17:0]   exp_q [$];
  int            n_chk;
  int            n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      i_empty[k]         = (fq[k].size() == 0);
      i_front[k*W +: W]  = front_r[k];
      i_front_vld[k]     = fv[k] & ~kill_vld;
    end
  endtask

  // One clock: sample pops before the edge, update the fifo model after it.
  task automatic tick();
    logic [N-1:0] p;
    @(negedge clk);
    p = o_pop;
    last_pop = p;
    if (p != '0) begin
      check("pop_onehot", {31'd0, $onehot(p)}, 32'd1);
      check("pop_nonempty", {28'd0, p & i_empty}, 32'd0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (p[k] && fq[k].size() > 0) begin
        front_r[k] = fq[k].pop_front();
        fv[k] = 1'b1;
      end else begin
        fv[k] = 1'b0;
      end
    end
    refresh();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_flush = 1'b0; i_rdy = 1'b0; kill_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      fq[k].delete();
      fv[k] = 1'b0;
      front_r[k] = '0;
    end
    refresh();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load(input int src, input logic [W-1:0] word, input bit expect_it);
    fq[src].push_back(word);
    if (expect_it) exp_q.push_back({word, 2'(src)});
    refresh();
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (!o_busy && exp_q.size() == 0 && i_empty == 4'b1111) break;
      tick();
    end
    check(name, {31'd0, i < 200}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_v, last_v, nv;
    n_chk = 0; n_fail = 0; last_pop = '0;

    // Scoreboard monitor: every accepted word must match the next expectation.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && !i_flush && o_vld && i_rdy) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_word: got data=%h src=%0d, required none", o_data, o_src_id);
          end else begin
            check("word", {14'd0, o_data, o_src_id}, {14'd0, exp_q.pop_front()});
          end
        end
      end
    join_none

    // Reset state
    do_reset();
    check("rst_vld", {31'd0, o_vld}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_data", {16'd0, o_data}, 32'd0);
    check("rst_src", {30'd0, o_src_id}, 32'd0);
    check("rst_pop", {28'd0, o_pop}, 32'd0);

    // Single source, latency
    i_rdy = 1'b1;
    load(2, 16'hA5A5, 1'b1);
    tick();
    check("single_pop", {28'd0, last_pop}, 32'h4);
    check("single_wait_vld", {31'd0, o_vld}, 32'd0);
    check("single_wait_busy", {31'd0, o_busy}, 32'd1);
    tick();
    check("single_vld", {31'd0, o_vld}, 32'd1);
    check("single_data", {16'd0, o_data}, 32'hA5A5);
    check("single_src", {30'd0, o_src_id}, 32'd2);
    tick();
    check("single_idle_vld", {31'd0, o_vld}, 32'd0);
    check("single_idle_busy", {31'd0, o_busy}, 32'd0);
    drain("single_drain");

    // Fairness: 4 sources x 3 words, expected order 0,1,2,3 repeated
    do_reset();
    i_rdy = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < N; k++) begin
        fq[k].push_back(16'h1000 | W'(k << 8) | W'(n));
        exp_q.push_back({16'h1000 | W'(k << 8) | W'(n), 2'(k)});
      end
    end
    refresh();
    first_v = -1; last_v = -1; nv = 0;
    for (int c = 1; c <= 28; c++) begin
      tick();
      if (o_vld) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        nv++;
      end
    end
    check("fair_count", nv, 32'd12);
    check("fair_first", first_v, 32'd2);
    check("fair_span", last_v - first_v, 32'd22);
    drain("fair_drain");

    // Backpressure
    do_reset();
    load(1, 16'h2100, 1'b1);
    load(2, 16'h2200, 1'b1);
    load(1, 16'h2101, 1'b1);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_vld", {31'd0, o_vld}, 32'd1);
      check("bp_data", {16'd0, o_data}, 32'h2100);
      check("bp_src", {30'd0, o_src_id}, 32'd1);
      tick();
      check("bp_nopop", {28'd0, last_pop}, 32'd0);
    end
    i_rdy = 1'b1;
    tick();
    check("bp_release_pop", {28'd0, last_pop}, 32'h4);
    drain("bp_drain");

    // Skip empties from rr_ptr=1: expect 3,0,3
    do_reset();
    i_rdy = 1'b1;
    load(0, 16'h3000, 1'b1);
    drain("skip_pre_drain");
    load(3, 16'h3300, 1'b1);
    load(0, 16'h3001, 1'b1);
    load(3, 16'h3301, 1'b1);
    exp_q.delete();
    exp_q.push_back({16'h3300, 2'd3});
    exp_q.push_back({16'h3001, 2'd0});
    exp_q.push_back({16'h3301, 2'd3});
    drain("skip_drain");

    // Flush in WAIT: word from src1 discarded, rr_ptr back to 0
    do_reset();
    i_rdy = 1'b1;
    load(1, 16'h4100, 1'b0);
    load(2, 16'h4200, 1'b0);
    tick();
    i_flush = 1'b1;
    load(0, 16'h4000, 1'b1);
    exp_q.push_back({16'h4200, 2'd2});
    tick();
    check("flushw_pop", {28'd0, last_pop}, 32'd0);
    i_flush = 1'b0;
    check("flushw_vld", {31'd0, o_vld}, 32'd0);
    check("flushw_busy", {31'd0, o_busy}, 32'd0);
    drain("flushw_drain");

    // Flush in HOLD: o_vld drops, data retained, no pop in flush cycle
    do_reset();
    load(1, 16'h5100, 1'b0);
    load(2, 16'h5200, 1'b0);
    tick();
    tick();
    check("flushh_vld_before", {31'd0, o_vld}, 32'd1);
    i_flush = 1'b1;
    i_rdy = 1'b1;
    tick();
    check("flushh_pop", {28'd0, last_pop}, 32'd0);
    i_flush = 1'b0;
    check("flushh_vld", {31'd0, o_vld}, 32'd0);
    check("flushh_data", {16'd0, o_data}, 32'h5100);
    check("flushh_src", {30'd0, o_src_id}, 32'd1);
    exp_q.push_back({16'h5200, 2'd2});
    drain("flushh_drain");

    // Missing front-valid sets sticky error
    do_reset();
    i_rdy = 1'b1;
    kill_vld = 1'b1;
    load(0, 16'h6000, 1'b1);
    tick();
    tick();
    check("err_set", {31'd0, o_err}, 32'd1);
    kill_vld = 1'b0;
    refresh();
    load(1, 16'h6100, 1'b1);
    drain("err_drain");
    check("err_sticky", {31'd0, o_err}, 32'd1);
    i_rdy = 1'b0;
    load(2, 16'h6200, 1'b0);
    tick();
    tick();
    check("rsthold_vld_before", {31'd0, o_vld}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rsthold_vld", {31'd0, o_vld}, 32'd0);
    check("rsthold_err", {31'd0, o_err}, 32'd0);
    check("rsthold_busy", {31'd0, o_busy}, 32'd0);
    i_rdy = 1'b1;
    load(0, 16'h6300, 1'b1);
    load(3, 16'h6330, 1'b1);
    drain("rsthold_drain");

    check("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
